// File: rtl/eu_insn_fetch.sv
// Instruction fetch front end: issues BUS_W beat reads, buffers beats, unpacks INSN_W words.
// Optional macro EU_FETCH_PERF_EN adds stall/starve performance counters.
module eu_insn_fetch #(
   parameter int BUS_W      = 128,
   parameter int INSN_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [31:0]       len_words,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              error_valid,
   output logic              rd_req_valid,
   input  logic              rd_req_ready,
   output logic [ADDR_W-1:0] rd_req_addr,
   input  logic              rd_rsp_valid,
   input  logic [BUS_W-1:0]  rd_rsp_data,
   output logic              insn_valid,
   input  logic              insn_ready,
   output logic [INSN_W-1:0] insn_data
`ifdef EU_FETCH_PERF_EN
   ,
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_starve_cycles
`endif
);

   localparam int WPB        = BUS_W / INSN_W;
   localparam int BEAT_BYTES = BUS_W / 8;
   localparam int OFF_W      = $clog2(BEAT_BYTES);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = PTR_W + 1;
   localparam int WSEL_W     = (WPB > 1) ? $clog2(WPB) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_base;
   logic [31:0]         r_len;
   logic [31:0]         r_beats_total;
   logic [31:0]         r_req_cnt;
   logic [31:0]         r_word_cnt;
   logic [CNT_W-1:0]    r_outstanding;
   logic [CNT_W-1:0]    r_fifo_count;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [WSEL_W-1:0]   r_wsel;
   logic [BUS_W-1:0]    r_fifo [FIFO_DEPTH];
   logic                r_done;
   logic                r_error;

   logic                w_misaligned;
   logic                w_start_idle;
   logic                w_start_fetch;
   logic                w_zero_start;
   logic [32:0]         w_len_ext;
   logic [31:0]         w_beats_start;
   logic [CNT_W:0]      w_credit_sum;
   logic                w_req_valid;
   logic                w_req_hs;
   logic                w_rsp_take;
   logic                w_abort;
   logic                w_flush;
   logic                w_push;
   logic                w_insn_valid;
   logic                w_hs;
   logic                w_last;
   logic                w_pop;
   logic                w_finish;
   logic [BUS_W-1:0]    w_head;
   logic [INSN_W-1:0]   w_word;

   assign w_misaligned  = |base_addr[OFF_W-1:0];
   assign w_start_idle  = (r_state == S_IDLE) && start;
   assign w_start_fetch = w_start_idle && !w_misaligned && (len_words != 32'd0);
   assign w_zero_start  = w_start_idle && !w_misaligned && (len_words == 32'd0);
   // Ceiling division done in 33 bits so a length near 2^32 cannot wrap.
   assign w_len_ext     = {1'b0, len_words} + 33'(WPB - 1);
   assign w_beats_start = 32'(w_len_ext / 33'(WPB));

   assign w_credit_sum  = {1'b0, r_outstanding} + {1'b0, r_fifo_count};
   assign w_req_valid   = (r_state == S_FETCH) && (r_req_cnt < r_beats_total) &&
                          (w_credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
   assign w_req_hs      = w_req_valid && rd_req_ready;
   assign w_rsp_take    = rd_rsp_valid && (r_outstanding != '0);
   assign w_abort       = (r_state == S_FETCH) && abort;
   assign w_flush       = w_abort || (r_state == S_DRAIN);
   assign w_push        = w_rsp_take && (r_state == S_FETCH) && !abort;

   assign w_insn_valid  = (r_state == S_FETCH) && (r_fifo_count != '0);
   assign w_hs          = w_insn_valid && insn_ready;
   assign w_last        = (r_word_cnt + 32'd1) == r_len;
   assign w_pop         = w_hs && ((r_wsel == WSEL_W'(WPB - 1)) || w_last);
   assign w_finish      = w_hs && w_last && !abort;
   assign w_head        = r_fifo[r_rd_ptr];
   assign w_word        = w_head[r_wsel * INSN_W +: INSN_W];

   assign busy          = (r_state != S_IDLE);
   assign done          = r_done;
   assign error_valid   = r_error;
   assign rd_req_valid  = w_req_valid;
   assign rd_req_addr   = r_base + (ADDR_W'(r_req_cnt) << OFF_W);
   assign insn_valid    = w_insn_valid;
   assign insn_data     = w_insn_valid ? w_word : '0;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state selection; abort outranks completion of the final word.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_fetch) w_state_nxt = S_FETCH;
            else               w_state_nxt = S_IDLE;
         end
         S_FETCH: begin
            if (abort)         w_state_nxt = S_DRAIN;
            else if (w_finish) w_state_nxt = S_IDLE;
            else               w_state_nxt = S_FETCH;
         end
         S_DRAIN: begin
            if (r_outstanding == '0) w_state_nxt = S_IDLE;
            else                     w_state_nxt = S_DRAIN;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Counters, FIFO pointers and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base        <= '0;
         r_len         <= 32'd0;
         r_beats_total <= 32'd0;
         r_req_cnt     <= 32'd0;
         r_word_cnt    <= 32'd0;
         r_outstanding <= '0;
         r_fifo_count  <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_wsel        <= '0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
      end else begin
         r_done  <= w_zero_start || w_finish;
         r_error <= w_start_idle && w_misaligned;
         if (w_start_fetch) begin
            r_base        <= base_addr;
            r_len         <= len_words;
            r_beats_total <= w_beats_start;
            r_req_cnt     <= 32'd0;
            r_word_cnt    <= 32'd0;
            r_wsel        <= '0;
         end else begin
            if (w_req_hs) r_req_cnt  <= r_req_cnt + 32'd1;
            if (w_hs)     r_word_cnt <= r_word_cnt + 32'd1;
            if (w_pop)     r_wsel <= '0;
            else if (w_hs) r_wsel <= r_wsel + WSEL_W'(1);
         end
         case ({w_req_hs, w_rsp_take})
            2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
         if (w_flush) begin
            r_fifo_count <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
               2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
               2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
               default: r_fifo_count <= r_fifo_count;
            endcase
         end
      end
   end

   // Beat storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      end else begin
         if (w_push) r_fifo[r_wr_ptr] <= rd_rsp_data;
      end
   end

`ifdef EU_FETCH_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_starve;

   // Saturating stall/starve counters over FETCH cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_stall  <= 32'd0;
         r_perf_starve <= 32'd0;
      end else if (w_start_idle && !w_misaligned) begin
         r_perf_stall  <= 32'd0;
         r_perf_starve <= 32'd0;
      end else if (r_state == S_FETCH) begin
         if (w_insn_valid && !insn_ready && (r_perf_stall != 32'hFFFF_FFFF))
            r_perf_stall <= r_perf_stall + 32'd1;
         if (!w_insn_valid && (r_perf_starve != 32'hFFFF_FFFF))
            r_perf_starve <= r_perf_starve + 32'd1;
      end
   end

   assign perf_stall_cycles  = r_perf_stall;
   assign perf_starve_cycles = r_perf_starve;
`endif

endmodule

// File: tb/tb_eu_insn_fetch.sv
// Self-checking bench for eu_insn_fetch: randomized memory/ready timing against
// a word-stream model where word k of a program is (base + 4k) ^ salt.
module tb_eu_insn_fetch;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [31:0]   base_addr;
   logic [31:0]   len_words;
   logic          abort;
   logic          busy;
   logic          done;
   logic          error_valid;
   logic          rd_req_valid;
   logic          rd_req_ready;
   logic [31:0]   rd_req_addr;
   logic          rd_rsp_valid = 1'b0;
   logic [127:0]  rd_rsp_data  = '0;
   logic          insn_valid;
   logic          insn_ready;
   logic [31:0]   insn_data;

   eu_insn_fetch dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .len_words(len_words), .abort(abort), .busy(busy), .done(done),
      .error_valid(error_valid), .rd_req_valid(rd_req_valid),
      .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
      .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_data(insn_data)
   );

   always #5 clk = ~clk;

   int            n_tests = 0;
   int            n_fail  = 0;
   int unsigned   cyc     = 0;
   logic [31:0]   salt    = 32'h0;
   int            mem_lat = 1;

   logic [31:0]   pend_addr[$];
   int unsigned   pend_due[$];
   logic [31:0]   got_q[$];
   logic [31:0]   req_q[$];
   int            done_cnt = 0, err_cnt = 0, reqv_cnt = 0, busy_cnt = 0, stab_err = 0;
   logic          prev_hold = 1'b0, prev_abort = 1'b0;
   logic [31:0]   prev_data = 32'h0;

   function automatic logic [127:0] beat_of(input logic [31:0] a, input logic [31:0] s);
      logic [127:0] b;
      for (int i = 0; i < 4; i++) b[32*i +: 32] = (a + 32'(4*i)) ^ s;
      return b;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: fixed latency, in order, never back-pressured.
   always @(negedge clk) begin
      #3;
      if (!rst_n) begin
         pend_addr.delete();
         pend_due.delete();
         rd_rsp_valid = 1'b0;
      end else begin
         if (rd_req_valid && rd_req_ready) begin
            pend_addr.push_back(rd_req_addr);
            pend_due.push_back(cyc + 1 + mem_lat);
         end
         if (pend_due.size() > 0 && pend_due[0] == cyc + 1) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = beat_of(pend_addr[0], salt);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end else begin
            rd_rsp_valid = 1'b0;
         end
      end
   end

   // Observer: values sampled here are the ones present at the next rising edge.
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (prev_hold && !prev_abort && (!insn_valid || insn_data !== prev_data)) stab_err++;
         if (insn_valid && insn_ready) got_q.push_back(insn_data);
         if (rd_req_valid && rd_req_ready) req_q.push_back(rd_req_addr);
         if (rd_req_valid) reqv_cnt++;
         if (done) done_cnt++;
         if (error_valid) err_cnt++;
         if (busy) busy_cnt++;
         prev_hold  = insn_valid && !insn_ready;
         prev_data  = insn_data;
         prev_abort = abort;
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] b, input logic [31:0] l);
      tick();
      base_addr = b;
      len_words = l;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic run_idle(input int max_cyc, input int rdy_pct, input int irdy_pct,
                           output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         rd_req_ready = (int'($urandom_range(99)) < rdy_pct);
         insn_ready   = (int'($urandom_range(99)) < irdy_pct);
         tick();
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
      end
      tick();
      tick();
   endtask

   function automatic logic [31:0] rand_base();
      return $urandom() & 32'hFFFF_FFF0;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = 32'h0; len_words = 32'h0;
      rd_req_ready = 1'b0; insn_ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      n_tests++;
      if ({busy, done, error_valid, rd_req_valid, insn_valid} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b exp 00000", {busy, done, error_valid, rd_req_valid, insn_valid});
      end
      n_tests++;
      if (insn_data !== 32'h0) begin
         n_fail++; $display("FAIL reset_data: got %h exp 0", insn_data);
      end
      n_tests++;
      if (rd_req_addr !== 32'h0) begin
         n_fail++; $display("FAIL reset_addr: got %h exp 0", rd_req_addr);
      end
   endtask

   task automatic test_basic();
      int g0 = got_q.size(), r0 = req_q.size(), d0 = done_cnt;
      bit to;
      salt = $urandom(); mem_lat = 1;
      do_start(32'h1000, 32'd9);
      run_idle(200, 100, 100, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL basic_timeout: busy stuck high exp low"); end
      n_tests++;
      if (req_q.size() - r0 != 3) begin
         n_fail++; $display("FAIL basic_nreq: got %0d exp 3", req_q.size() - r0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (req_q[r0+i] !== 32'h1000 + 32'(16*i)) begin
               n_fail++; $display("FAIL basic_addr%0d: got %h exp %h", i, req_q[r0+i], 32'h1000 + 32'(16*i));
            end
         end
      end
      n_tests++;
      if (got_q.size() - g0 != 9) begin
         n_fail++; $display("FAIL basic_nwords: got %0d exp 9", got_q.size() - g0);
      end else begin
         for (int k = 0; k < 9; k++) begin
            n_tests++;
            if (got_q[g0+k] !== ((32'h1000 + 32'(4*k)) ^ salt)) begin
               n_fail++; $display("FAIL basic_word%0d: got %h exp %h", k, got_q[g0+k], (32'h1000 + 32'(4*k)) ^ salt);
            end
         end
      end
      n_tests++;
      if (done_cnt - d0 != 1) begin
         n_fail++; $display("FAIL basic_done: got %0d pulses exp 1", done_cnt - d0);
      end
   endtask

   task automatic test_backpressure();
      int g0 = got_q.size(), r0 = req_q.size(), d0 = done_cnt, s0 = stab_err;
      logic [31:0] b = rand_base();
      bit to;
      salt = $urandom(); mem_lat = $urandom_range(1, 3);
      rd_req_ready = 1'b1; insn_ready = 1'b0;
      do_start(b, 32'd20);
      repeat (50) tick();
      n_tests++;
      if (req_q.size() - r0 != 4) begin
         n_fail++; $display("FAIL bp_credit: got %0d requests exp 4", req_q.size() - r0);
      end
      n_tests++;
      if (got_q.size() != g0) begin
         n_fail++; $display("FAIL bp_nowords: got %0d words exp 0", got_q.size() - g0);
      end
      run_idle(600, 100, 50, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL bp_timeout: busy stuck high exp low"); end
      n_tests++;
      if (req_q.size() - r0 != 5) begin
         n_fail++; $display("FAIL bp_nreq: got %0d exp 5", req_q.size() - r0);
      end
      n_tests++;
      if (got_q.size() - g0 != 20) begin
         n_fail++; $display("FAIL bp_nwords: got %0d exp 20", got_q.size() - g0);
      end else begin
         for (int k = 0; k < 20; k++) begin
            n_tests++;
            if (got_q[g0+k] !== ((b + 32'(4*k)) ^ salt)) begin
               n_fail++; $display("FAIL bp_word%0d: got %h exp %h", k, got_q[g0+k], (b + 32'(4*k)) ^ salt);
            end
         end
      end
      n_tests++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL bp_done: got %0d exp 1", done_cnt - d0); end
      n_tests++;
      if (stab_err != s0) begin n_fail++; $display("FAIL bp_stable: got %0d exp 0", stab_err - s0); end
   endtask

   task automatic test_misaligned();
      int e0 = err_cnt, v0 = reqv_cnt, b0 = busy_cnt, d0 = done_cnt;
      do_start(32'h1004, 32'd8);
      n_tests++;
      if (error_valid !== 1'b1) begin n_fail++; $display("FAIL mis_err_now: got %b exp 1", error_valid); end
      repeat (5) tick();
      n_tests++;
      if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL mis_err_cnt: got %0d exp 1", err_cnt - e0); end
      n_tests++;
      if (reqv_cnt != v0 || busy_cnt != b0 || done_cnt != d0) begin
         n_fail++; $display("FAIL mis_quiet: got req %0d busy %0d done %0d exp 0 0 0",
                            reqv_cnt - v0, busy_cnt - b0, done_cnt - d0);
      end
   endtask

   task automatic test_zero_len();
      int e0 = err_cnt, v0 = reqv_cnt, b0 = busy_cnt, d0 = done_cnt;
      do_start(32'h2000, 32'd0);
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL zero_done_now: got done %b busy %b exp 1 0", done, busy);
      end
      repeat (5) tick();
      n_tests++;
      if (done_cnt - d0 != 1 || reqv_cnt != v0 || busy_cnt != b0 || err_cnt != e0) begin
         n_fail++; $display("FAIL zero_counts: got done %0d req %0d busy %0d err %0d exp 1 0 0 0",
                            done_cnt - d0, reqv_cnt - v0, busy_cnt - b0, err_cnt - e0);
      end
   endtask

   task automatic test_abort();
      int g0 = got_q.size(), d0 = done_cnt, n_ab;
      logic [31:0] b = rand_base();
      bit to;
      salt = $urandom(); mem_lat = 6;
      rd_req_ready = 1'b1; insn_ready = 1'b1;
      do_start(b, 32'd16);
      for (int i = 0; i < 300; i++) begin
         tick();
         if (got_q.size() - g0 >= 6) break;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_ab = got_q.size() - g0;
      n_tests++;
      if (insn_valid !== 1'b0 || rd_req_valid !== 1'b0) begin
         n_fail++; $display("FAIL abort_drop: got valid %b req %b exp 0 0", insn_valid, rd_req_valid);
      end
      run_idle(100, 100, 100, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL abort_timeout: busy stuck high exp low"); end
      n_tests++;
      if (got_q.size() - g0 != n_ab) begin
         n_fail++; $display("FAIL abort_extra: got %0d words exp %0d", got_q.size() - g0, n_ab);
      end
      for (int k = 0; k < n_ab; k++) begin
         n_tests++;
         if (got_q[g0+k] !== ((b + 32'(4*k)) ^ salt)) begin
            n_fail++; $display("FAIL abort_word%0d: got %h exp %h", k, got_q[g0+k], (b + 32'(4*k)) ^ salt);
         end
      end
      n_tests++;
      if (done_cnt != d0) begin n_fail++; $display("FAIL abort_nodone: got %0d exp 0", done_cnt - d0); end
      n_tests++;
      if (pend_due.size() != 0) begin
         n_fail++; $display("FAIL abort_outstanding: got %0d pending exp 0", pend_due.size());
      end
   endtask

   task automatic test_reset_mid();
      int g0, r0, d0;
      bit to;
      salt = $urandom(); mem_lat = 3;
      rd_req_ready = 1'b1; insn_ready = 1'b1;
      do_start(rand_base(), 32'd16);
      repeat (8) tick();
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({busy, done, error_valid, rd_req_valid, insn_valid} !== 5'b0 || insn_data !== 32'h0) begin
         n_fail++; $display("FAIL rstmid_outputs: got %b/%h exp 00000/0",
                            {busy, done, error_valid, rd_req_valid, insn_valid}, insn_data);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      g0 = got_q.size(); r0 = req_q.size(); d0 = done_cnt;
      salt = $urandom(); mem_lat = 1;
      do_start(32'h0, 32'd4);
      run_idle(100, 100, 100, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL rstmid_timeout: busy stuck high exp low"); end
      n_tests++;
      if (req_q.size() - r0 != 1 || (req_q.size() > r0 && req_q[r0] !== 32'h0)) begin
         n_fail++; $display("FAIL rstmid_req: got %0d requests exp 1 at 0", req_q.size() - r0);
      end
      n_tests++;
      if (got_q.size() - g0 != 4) begin
         n_fail++; $display("FAIL rstmid_nwords: got %0d exp 4", got_q.size() - g0);
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (got_q[g0+k] !== (32'(4*k) ^ salt)) begin
               n_fail++; $display("FAIL rstmid_word%0d: got %h exp %h", k, got_q[g0+k], 32'(4*k) ^ salt);
            end
         end
      end
      n_tests++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL rstmid_done: got %0d exp 1", done_cnt - d0); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int g0 = got_q.size(), r0 = req_q.size(), d0 = done_cnt, s0 = stab_err;
         int len = $urandom_range(1, 40);
         int nb  = (len + 3) / 4;
         logic [31:0] b = rand_base();
         bit to;
         salt = $urandom(); mem_lat = $urandom_range(1, 4);
         do_start(b, 32'(len));
         run_idle(2000, 70, 60, to);
         n_tests++;
         if (to) begin n_fail++; $display("FAIL rnd%0d_timeout: busy stuck high exp low", it); end
         n_tests++;
         if (req_q.size() - r0 != nb) begin
            n_fail++; $display("FAIL rnd%0d_nreq: got %0d exp %0d", it, req_q.size() - r0, nb);
         end else begin
            for (int i = 0; i < nb; i++) begin
               n_tests++;
               if (req_q[r0+i] !== b + 32'(16*i)) begin
                  n_fail++; $display("FAIL rnd%0d_addr%0d: got %h exp %h", it, i, req_q[r0+i], b + 32'(16*i));
               end
            end
         end
         n_tests++;
         if (got_q.size() - g0 != len) begin
            n_fail++; $display("FAIL rnd%0d_nwords: got %0d exp %0d", it, got_q.size() - g0, len);
         end else begin
            for (int k = 0; k < len; k++) begin
               n_tests++;
               if (got_q[g0+k] !== ((b + 32'(4*k)) ^ salt)) begin
                  n_fail++; $display("FAIL rnd%0d_word%0d: got %h exp %h", it, k, got_q[g0+k], (b + 32'(4*k)) ^ salt);
               end
            end
         end
         n_tests++;
         if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL rnd%0d_done: got %0d exp 1", it, done_cnt - d0); end
         n_tests++;
         if (stab_err != s0) begin n_fail++; $display("FAIL rnd%0d_stable: got %0d exp 0", it, stab_err - s0); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_misaligned();
      test_zero_len();
      test_abort();
      test_basic();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/eu_insn_fetch.md
Name: eu_insn_fetch

Overview:
- Upstream instruction-fetch stage of the EU that feeds the instruction sequencer's 32-bit valid/ready instruction stream.
- Issues BUS_W-wide read requests for a program buffer starting at a base address.
- Buffers returned beats in a small credit-limited FIFO and unpacks each beat into INSN_W words, little-endian: word 0 = bits [31:0].
- Stops after exactly len_words words have been handed downstream.

Parameters:
BUS_W, 128, memory beat width in bits; must be a multiple of INSN_W.
INSN_W, 32, instruction word width in bits.
FIFO_DEPTH, 4, beat buffer depth; power of 2, at least 2.
ADDR_W, 32, byte address width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a fetch; sampled only in IDLE
base_addr  in  ADDR_W  byte address of the program; must be aligned to BUS_W/8
len_words  in  32  number of INSN_W words to deliver
abort  in  1  cancels an active fetch
busy  out  1  high in any state other than IDLE
done  out  1  1-cycle pulse after the last word handshakes, or after a zero-length start
error_valid  out  1  1-cycle pulse when start is rejected because base_addr is misaligned
rd_req_valid  out  1  read request valid
rd_req_ready  in  1  read request accept
rd_req_addr  out  ADDR_W  beat byte address
rd_rsp_valid  in  1  read data valid; returns in order; cannot be back-pressured
rd_rsp_data  in  BUS_W  read data
insn_valid  out  1  word valid toward the sequencer
insn_ready  in  1  sequencer accept
insn_data  out  INSN_W  instruction word

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs are 0. FIFO is empty. All counters are 0. State is IDLE.
- Definitions:
  - WPB = BUS_W/INSN_W words per beat.
  - beats_total = ceil(len_words/WPB).
- States: IDLE, FETCH, DRAIN.
- IDLE, on start:
  - base_addr[log2(BUS_W/8)-1:0] != 0: pulse error_valid next cycle, stay in IDLE, issue no requests.
  - len_words == 0: pulse done next cycle, stay in IDLE.
  - Otherwise: latch base_addr and len_words, clear the counters, go to FETCH.
  - start while busy is ignored.
- FETCH, request side:
  - rd_req_valid = (req_cnt < beats_total) && (outstanding + fifo_count < FIFO_DEPTH).
  - rd_req_addr = base + req_cnt*(BUS_W/8).
  - On a request handshake: req_cnt++ and outstanding++.
  - On rd_rsp_valid: the beat is written into the FIFO and outstanding--.
  - A request handshake and a response in the same cycle leave outstanding unchanged.
  - The credit rule guarantees the FIFO never overflows.
- FETCH, output side:
  - insn_valid = FIFO non-empty.
  - insn_data = head beat word wsel.
  - A response written in cycle N is visible on insn_valid in cycle N+1; no bypass.
  - Stable rule: insn_data is held until handshake (insn_valid && insn_ready).
  - On each handshake: word_cnt++ and wsel++.
  - The head beat is popped when wsel == WPB-1 or when word_cnt+1 == len_words. On pop, wsel returns to 0.
  - Words past len_words in the last beat are discarded.
  - The handshake that delivers word len_words-1 pulses done the next cycle and moves to IDLE.
- Abort:
  - abort in FETCH moves to DRAIN the next cycle. In DRAIN:
    - rd_req_valid = 0 and insn_valid = 0.
    - The FIFO is flushed and arriving responses are discarded.
    - When outstanding == 0, go to IDLE with no done pulse.
  - abort in IDLE or DRAIN has no effect.
  - abort and a final word handshake in the same cycle: the word counts as delivered, abort wins, no done pulse.
- rd_rsp_valid with outstanding == 0: dropped, no state change.
- Reset mid-operation: immediate return to reset values. Outstanding responses are not tracked afterwards.
- Width rules:
  - Address arithmetic wraps modulo 2^ADDR_W.
  - word_cnt and req_cnt are 32 bits.
  - outstanding and fifo_count are clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro EU_FETCH_PERF_EN.
- When defined:
  - Adds output perf_stall_cycles [31:0], counting FETCH cycles with insn_valid && !insn_ready.
  - Adds output perf_starve_cycles [31:0], counting FETCH cycles with !insn_valid.
  - Both clear on an accepted start and on reset, and saturate at 0xFFFFFFFF.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- base 0x1000, len 9, rd_req_ready=1, 1-cycle memory latency, insn_ready=1:
  - 3 requests at 0x1000, 0x1010, 0x1020.
  - 9 words in order, word 0 = beat0[31:0].
  - Words 9..11 discarded; done pulse exactly once.
- len 20, insn_ready=0 for 50 cycles then 1:
  - Requests stop once outstanding + fifo_count == 4.
  - No beat lost; all 20 words then delivered in order; done pulse.
- start with base 0x1004 → error_valid pulse, no rd_req_valid, busy stays 0.
- start with len 0 → done pulse next cycle, no requests.
- len 16, abort after word 5 with 2 responses outstanding:
  - insn_valid drops.
  - The 2 late responses are discarded.
  - busy falls once outstanding reaches 0; no done pulse.
  - A new start then fetches correctly.
- Assert rst_n low mid-FETCH, release, then start base 0x0, len 4 → all outputs reset; exactly 1 request; 4 words; done pulse.
